// File: rtl/kypd_scan_ctrl.sv
// kypd_scan_ctrl
// Column-scan controller for the 4x4 Pmod keypad. One column is driven low at
// a time, and the synchronized rows are sampled at the end of each column
// dwell. The 16-key snapshot is debounced across consecutive full scans. A
// one-cycle event is emitted when the accepted state goes from no keys down
// to exactly one key down.
//
// Ports
//   clk       in   system clock, all state on rising edge
//   rst_n     in   asynchronous active-low reset
//   Row[3:0]  in   keypad rows, active low, asynchronous to clk
//   Col[3:0]  out  keypad column drive, exactly one bit low
//   key_code  out  position of last reported key, col*4 + row
//   key_valid out  one-cycle pulse when key_code is updated
//   key_held  out  accepted state has exactly one key down
//   multi     out  accepted state has two or more keys down
module kypd_scan_ctrl #(
    parameter int SCAN_DIV  = 100000,
    parameter int DEB_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Row,
    output logic [3:0] Col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       multi
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int STB_W = $clog2(DEB_SCANS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEB_SCANS - 1);

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    // Index of the set bit; only called when exactly one bit is set.
    function automatic logic [3:0] onehot_index(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                idx = i[3:0];
            end
        end
        return idx;
    endfunction

    logic [3:0]       row_sync_p0;
    logic [3:0]       row_sync_p1;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       c;
    logic [3:0]       col_q;
    logic [15:0]      snap;
    logic [15:0]      prev_snap;
    logic [15:0]      accepted;
    logic [STB_W-1:0] stable;

    logic [3:0]       pressed;
    logic             sample;
    logic             scan_done;
    logic [15:0]      snap_next;
    logic [STB_W-1:0] stable_next;
    logic             accept;
    logic [15:0]      acc_next;
    logic [4:0]       acc_pop;
    logic             new_event;

    assign Col = col_q;

    always_comb begin
        pressed   = ~row_sync_p1;
        sample    = (cnt == CNT_LAST);
        scan_done = sample && (c == 2'd3);

        snap_next = snap;
        if (sample) begin
            snap_next[{c, 2'b00} +: 4] = pressed;
        end

        // Comparison uses the snapshot including the column just sampled.
        if (snap_next == prev_snap) begin
            stable_next = (stable == STB_MAX) ? stable : stable + 1'b1;
        end else begin
            stable_next = '0;
        end

        accept    = scan_done && (stable_next == STB_MAX) && (snap_next != accepted);
        acc_next  = accept ? snap_next : accepted;
        acc_pop   = popcount16(acc_next);
        new_event = accept && (accepted == 16'd0) && (acc_pop == 5'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_sync_p0 <= 4'b1111;
            row_sync_p1 <= 4'b1111;
            cnt         <= '0;
            c           <= 2'd0;
            col_q       <= 4'b1110;
            snap        <= 16'd0;
            prev_snap   <= 16'd0;
            accepted    <= 16'd0;
            stable      <= '0;
            key_code    <= 4'd0;
            key_valid   <= 1'b0;
            key_held    <= 1'b0;
            multi       <= 1'b0;
        end else begin
            // Stage p0/p1: two-flop synchronizer on the raw row pins
            row_sync_p0 <= Row;
            row_sync_p1 <= row_sync_p0;

            // Column dwell and rotation; Col moves the cycle after sampling
            if (sample) begin
                cnt   <= '0;
                c     <= c + 1'b1;
                col_q <= {col_q[2:0], col_q[3]};
            end else begin
                cnt   <= cnt + 1'b1;
            end

            snap <= snap_next;

            // Full-scan debounce
            if (scan_done) begin
                prev_snap <= snap_next;
                stable    <= stable_next;
            end
            accepted <= acc_next;

            // Outputs follow the acceptance decision by one cycle
            key_valid <= new_event;
            if (new_event) begin
                key_code <= onehot_index(snap_next);
            end
            key_held <= (acc_pop == 5'd1);
            multi    <= (acc_pop >= 5'd2);
        end
    end

endmodule
